// File: rtl/exc_sequencer.sv
// exc_sequencer: exception-entry / ERET sequencer (flush -> EPC commit -> redirect).
// Optional feature: define EXC_SEQ_STATS_EN to build the saturating accepted-exception
// counter on exc_count_o; without it exc_count_o is tied to zero.
module exc_sequencer #(
    parameter logic [31:0] VECTOR_BASE  = 32'h8000_0180,
    parameter logic [31:0] REFILL_BASE  = 32'h8000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_pause_i,
    input  logic        intr_i,
    input  logic        exc_addr_error_i,
    input  logic        exc_tlb_refill_i,
    input  logic        exc_tlb_other_i,
    input  logic        exc_syscall_i,
    input  logic        instr_eret_i,
    input  logic [31:0] exc_pc_i,
    input  logic        in_delay_slot_i,
    input  logic        status_exl_i,
    input  logic [31:0] cp0_epc_i,
    output logic        flush_o,
    output logic        busy_o,
    output logic        epc_wen_o,
    output logic [31:0] epc_data_o,
    output logic [4:0]  exc_code_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic [15:0] exc_count_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        eret_q;
    logic        exl_q;
    logic        any_exc;
    logic        accept;
    logic [4:0]  code;
    logic [31:0] target;

    // Fixed-priority source arbitration and target selection for the IDLE accept edge
    always_comb begin
        any_exc = intr_i | exc_addr_error_i | exc_tlb_refill_i | exc_tlb_other_i | exc_syscall_i;
        accept  = (state == IDLE) && !cpu_pause_i && (any_exc || instr_eret_i);
        code    = intr_i ? 5'd0 :
                  exc_addr_error_i ? 5'd4 :
                  (exc_tlb_refill_i | exc_tlb_other_i) ? 5'd2 : 5'd8;
        target  = !any_exc ? cp0_epc_i :
                  (!intr_i && !exc_addr_error_i && exc_tlb_refill_i && !status_exl_i) ? REFILL_BASE :
                  VECTOR_BASE;
    end

    // Sequencer FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            eret_q           <= 1'b0;
            exl_q            <= 1'b0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
            epc_wen_o        <= 1'b0;
            epc_data_o       <= 32'h0;
            exc_code_o       <= 5'd0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'h0;
        end else begin
            epc_wen_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= FLUSH;
                        cnt           <= CNT_INIT;
                        eret_q        <= !any_exc;
                        exl_q         <= status_exl_i;
                        redirect_pc_o <= target;
                        flush_o       <= 1'b1;
                        busy_o        <= 1'b1;
                        if (any_exc) begin
                            exc_code_o <= code;
                            epc_data_o <= exc_pc_i - (in_delay_slot_i ? 32'd4 : 32'd0);
                        end
                    end
                end
                FLUSH: begin
                    if (!cpu_pause_i) begin
                        if (cnt == 4'd0) begin
                            flush_o <= 1'b0;
                            if (eret_q) begin
                                state            <= REDIRECT;
                                redirect_valid_o <= 1'b1;
                            end else begin
                                state     <= COMMIT;
                                epc_wen_o <= !exl_q;
                            end
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                COMMIT: begin
                    state            <= REDIRECT;
                    redirect_valid_o <= 1'b1;
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        state            <= IDLE;
                        redirect_valid_o <= 1'b0;
                        busy_o           <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXC_SEQ_STATS_EN
    // Saturating count of accepted exceptions (ERET excluded), cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            exc_count_o <= 16'h0;
        else if (accept && any_exc && exc_count_o != 16'hFFFF)
            exc_count_o <= exc_count_o + 16'd1;
    end
`else
    assign exc_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: scoreboard bench for exc_sequencer (EPC writes and redirects).
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_pause_i = 1'b0;
    logic        intr_i = 1'b0;
    logic        exc_addr_error_i = 1'b0;
    logic        exc_tlb_refill_i = 1'b0;
    logic        exc_tlb_other_i = 1'b0;
    logic        exc_syscall_i = 1'b0;
    logic        instr_eret_i = 1'b0;
    logic [31:0] exc_pc_i = 32'h0;
    logic        in_delay_slot_i = 1'b0;
    logic        status_exl_i = 1'b0;
    logic [31:0] cp0_epc_i = 32'h0;
    logic        redirect_ready_i = 1'b1;
    logic        flush_o;
    logic        busy_o;
    logic        epc_wen_o;
    logic [31:0] epc_data_o;
    logic [4:0]  exc_code_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] exc_count_o;

    exc_sequencer dut (
        .clk(clk), .reset(reset), .cpu_pause_i(cpu_pause_i), .intr_i(intr_i),
        .exc_addr_error_i(exc_addr_error_i), .exc_tlb_refill_i(exc_tlb_refill_i),
        .exc_tlb_other_i(exc_tlb_other_i), .exc_syscall_i(exc_syscall_i),
        .instr_eret_i(instr_eret_i), .exc_pc_i(exc_pc_i), .in_delay_slot_i(in_delay_slot_i),
        .status_exl_i(status_exl_i), .cp0_epc_i(cp0_epc_i), .flush_o(flush_o),
        .busy_o(busy_o), .epc_wen_o(epc_wen_o), .epc_data_o(epc_data_o),
        .exc_code_o(exc_code_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
        .exc_count_o(exc_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] val;
        logic [4:0]  code;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  hold = 0;
    int  exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef EXC_SEQ_STATS_EN
        return 32'(exp_cnt);
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk_zero(input string p);
        chk({p, "_flush"}, {31'd0, flush_o}, 0);
        chk({p, "_busy"}, {31'd0, busy_o}, 0);
        chk({p, "_wen"}, {31'd0, epc_wen_o}, 0);
        chk({p, "_data"}, epc_data_o, 0);
        chk({p, "_code"}, {27'd0, exc_code_o}, 0);
        chk({p, "_rv"}, {31'd0, redirect_valid_o}, 0);
        chk({p, "_rpc"}, redirect_pc_o, 0);
        chk({p, "_cnt"}, {16'd0, exc_count_o}, 0);
    endtask

    // Ready throttling plus scoreboard pops on EPC writes and redirect handshakes
    always @(negedge clk) begin
        if (!reset) begin
            redirect_ready_i = 1'b1;
        end else begin
            if (redirect_valid_o && hold > 0) begin
                redirect_ready_i = 1'b0;
                hold--;
            end else begin
                redirect_ready_i = 1'b1;
            end
            if (epc_wen_o) begin
                if (q.size() == 0 || q[0].redir) chk("sb_epc_unexpected", 1, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("sb_epc_data", epc_data_o, mon_e.val);
                    chk("sb_exc_code", {27'd0, exc_code_o}, {27'd0, mon_e.code});
                end
            end
            if (redirect_valid_o) begin
                if (q.size() == 0 || !q[0].redir) chk("sb_redir_unexpected", 1, 0);
                else begin
                    chk("sb_redir_pc", redirect_pc_o, q[0].val);
                    if (redirect_ready_i) void'(q.pop_front());
                end
            end
        end
    end

    function automatic ev_t mk(input logic r, input logic [31:0] v, input logic [4:0] c);
        ev_t e;
        e.redir = r;
        e.val = v;
        e.code = c;
        return e;
    endfunction

    // src bits: [5] intr [4] addr_error [3] tlb_refill [2] tlb_other [1] syscall [0] eret
    task automatic fire(input logic [5:0] src, input logic [31:0] pc, input logic ds,
                        input logic exl, input logic [31:0] epc, input int p_at, input int p_len,
                        output int nf, output int nb, output int nw, output int fw,
                        output int fr, output int nr);
        bit done = 0;
        @(negedge clk);
        {intr_i, exc_addr_error_i, exc_tlb_refill_i, exc_tlb_other_i, exc_syscall_i, instr_eret_i} = src;
        exc_pc_i = pc;
        in_delay_slot_i = ds;
        status_exl_i = exl;
        cp0_epc_i = epc;
        @(posedge clk);
        #1;
        {intr_i, exc_addr_error_i, exc_tlb_refill_i, exc_tlb_other_i, exc_syscall_i, instr_eret_i} = 6'b0;
        exc_pc_i = 32'hDEAD_BEEF;
        in_delay_slot_i = ~ds;
        status_exl_i = ~exl;
        cp0_epc_i = 32'h1234_5678;
        nf = 0; nb = 0; nw = 0; nr = 0; fw = -1; fr = -1;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (k == p_at) cpu_pause_i = 1'b1;
            if (k == p_at + p_len) cpu_pause_i = 1'b0;
            if (!busy_o) done = 1;
            else begin
                nb++;
                if (flush_o) nf++;
                if (epc_wen_o) begin nw++; if (fw < 0) fw = k; end
                if (redirect_valid_o) begin nr++; if (fr < 0) fr = k; end
            end
        end
        cpu_pause_i = 1'b0;
        if (!done) chk("timeout_busy", 1, 0);
    endtask

    int nf, nb, nw, fw, fr, nr, nrv;

    initial begin
        #12;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        // syscall, EXL=0, no delay slot
        q.push_back(mk(0, 32'h8000_1000, 5'd8));
        q.push_back(mk(1, 32'h8000_0180, 5'd0));
        fire(6'b000010, 32'h8000_1000, 0, 0, 32'h0, -100, 0, nf, nb, nw, fw, fr, nr);
        exp_cnt++;
        chk("sys_flush_cycles", nf, 2);
        chk("sys_wen_cycle", fw, 3);
        chk("sys_wen_count", nw, 1);
        chk("sys_redir_cycle", fr, 4);
        chk("sys_busy_cycles", nb, 4);
        chk("sys_count", {16'd0, exc_count_o}, cnt_exp());

        // TLB refill in a delay slot, EXL=0 -> refill vector
        q.push_back(mk(0, 32'h0040_0004, 5'd2));
        q.push_back(mk(1, 32'h8000_0000, 5'd0));
        fire(6'b001000, 32'h0040_0008, 1, 0, 32'h0, -100, 0, nf, nb, nw, fw, fr, nr);
        exp_cnt++;
        chk("refill_wen_count", nw, 1);
        chk("refill_redir_cycle", fr, 4);

        // TLB refill with EXL=1: no EPC write, general vector
        q.push_back(mk(1, 32'h8000_0180, 5'd0));
        fire(6'b001000, 32'h0040_0008, 1, 1, 32'h0, -100, 0, nf, nb, nw, fw, fr, nr);
        exp_cnt++;
        chk("refill_exl_wen_count", nw, 0);
        chk("refill_exl_code", {27'd0, exc_code_o}, 2);
        chk("refill_exl_busy", nb, 4);

        // interrupt and syscall together: interrupt wins, syscall dropped
        q.push_back(mk(0, 32'h0000_2000, 5'd0));
        q.push_back(mk(1, 32'h8000_0180, 5'd0));
        fire(6'b100010, 32'h0000_2000, 0, 0, 32'h0, -100, 0, nf, nb, nw, fw, fr, nr);
        exp_cnt++;
        chk("intr_wen_count", nw, 1);
        chk("intr_count", {16'd0, exc_count_o}, cnt_exp());

        // TLB other plus syscall: code 2, general vector (not refill)
        q.push_back(mk(0, 32'h0000_3000, 5'd2));
        q.push_back(mk(1, 32'h8000_0180, 5'd0));
        fire(6'b000110, 32'h0000_3000, 0, 0, 32'h0, -100, 0, nf, nb, nw, fw, fr, nr);
        exp_cnt++;
        chk("tlbo_wen_count", nw, 1);

        // ERET with fetch stalling ready for 3 cycles
        hold = 3;
        q.push_back(mk(1, 32'h0040_0100, 5'd0));
        fire(6'b000001, 32'h0, 0, 0, 32'h0040_0100, -100, 0, nf, nb, nw, fw, fr, nr);
        chk("eret_wen_count", nw, 0);
        chk("eret_redir_cycle", fr, 3);
        chk("eret_redir_held", nr, 4);
        chk("eret_busy", nb, 6);
        chk("eret_count", {16'd0, exc_count_o}, cnt_exp());

        // address error at pc 0 in a delay slot, pause 3 cycles during flush
        q.push_back(mk(0, 32'hFFFF_FFFC, 5'd4));
        q.push_back(mk(1, 32'h8000_0180, 5'd0));
        fire(6'b010000, 32'h0000_0000, 1, 0, 32'h0, 1, 3, nf, nb, nw, fw, fr, nr);
        exp_cnt++;
        chk("pause_flush_cycles", nf, 5);
        chk("pause_wen_cycle", fw, 6);
        chk("pause_redir_cycle", fr, 7);
        chk("pause_busy", nb, 7);
        chk("pause_count", {16'd0, exc_count_o}, cnt_exp());
        chk("queue_drained", q.size(), 0);

        // reset asserted while a redirect is pending
        hold = 20;
        q.push_back(mk(1, 32'h0000_4000, 5'd0));
        @(negedge clk);
        instr_eret_i = 1'b1;
        cp0_epc_i = 32'h0000_4000;
        @(posedge clk);
        #1;
        instr_eret_i = 1'b0;
        nrv = 0;
        for (int k = 0; k < 20 && nrv == 0; k++) begin
            @(negedge clk);
            if (redirect_valid_o) nrv = 1;
        end
        chk("rst_mid_reached_redirect", nrv, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("rst_mid");
        q.delete();
        hold = 0;
        @(negedge clk);
        reset = 1'b1;
        nrv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (redirect_valid_o || epc_wen_o || busy_o) nrv++;
        end
        chk("post_rst_idle", nrv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
